module_arbitro_mux4: RTL
========================

MODULE_ARBITRO_MUX4 -- requirements
Module: module_arbitro_mux4

Interface
REQ-001 Parameter: BITS, default 4, data width of every requester port and of dato_o.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  4  request from requester k on bit k.
REQ-005 dato0_i, dato1_i, dato2_i, dato3_i  input  BITS each  data from requesters 0..3.
REQ-006 ready_i  input  1  downstream consumer accepts dato_o.
REQ-007 gnt_o  output  4  one-hot grant pulse; bit k = data from requester k captured.
REQ-008 selec_o  output  2  index of the granted requester, registered.
REQ-009 dato_o  output  BITS  registered copy of the granted requester's data.
REQ-010 valid_o  output  1  dato_o holds a transfer not yet accepted.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and ESPERA.
REQ-012 The block SHALL keep a 2-bit pointer ultimo holding the index of the last requester whose transfer completed.
REQ-013 Round-robin priority SHALL be (ultimo+1), (ultimo+2), (ultimo+3), (ultimo+4) mod 4, highest first.
REQ-014 In IDLE with req_i = 0, the block SHALL stay in IDLE and hold all outputs unchanged, except gnt_o = 0 and valid_o = 0.
REQ-015 In IDLE with req_i != 0, at the next edge the block SHALL do all of the following:
- select k, the highest-priority set bit;
- set selec_o = k;
- load dato_o with datok_i (equivalent to a 4-to-1 mux selected by k);
- set valid_o = 1;
- set gnt_o = one-hot(k);
- enter ESPERA.
REQ-016 gnt_o SHALL be high for exactly one cycle per transfer: the first cycle of ESPERA. It SHALL be 0 in all other cycles.
REQ-017 In ESPERA, valid_o, dato_o and selec_o SHALL stay stable regardless of req_i or dato*_i changes.
REQ-018 In ESPERA with ready_i = 1 at an edge, the block SHALL do all of the following:
- clear valid_o;
- set ultimo = selec_o;
- return to IDLE.
REQ-019 In ESPERA with ready_i = 0, the block SHALL remain in ESPERA indefinitely; there is no timeout.
REQ-020 ready_i SHALL be ignored in IDLE.
REQ-021 Latency: a request seen in IDLE at edge n SHALL give valid_o = 1 after edge n.
REQ-022 Maximum throughput SHALL be one transfer per 2 cycles (ESPERA, then IDLE).
REQ-023 A requester may keep req_i high after its grant; it SHALL then compete again under the updated priority.
REQ-024 A request dropped before being granted SHALL simply not be served; no request is stored.
REQ-025 selec_o SHALL retain its last value in IDLE.
REQ-026 ultimo SHALL wrap from 3 to 0 by modulo-4 arithmetic.
REQ-027 No requester SHALL wait more than 3 other transfers while its req_i stays high.

Reset
REQ-028 While rst_n_i = 0, the block SHALL hold, without waiting for a clock edge:
- state = IDLE;
- valid_o = 0, gnt_o = 0, selec_o = 0, dato_o = 0;
- ultimo = 3, so requester 0 has first priority.
REQ-029 Reset asserted in ESPERA SHALL discard the pending transfer; it SHALL NOT be re-issued after release.
REQ-030 The first arbitration SHALL occur at the first rising edge with rst_n_i = 1 and req_i != 0.

Verification (BITS = 4)
REQ-031 Reset: rst_n_i = 0 mid-cycle -> all outputs 0 immediately. Then release and req_i = 1111 -> first gnt_o = 0001.
REQ-032 Single request: req_i = 0100, dato2_i = 4'hA, ready_i = 1 -> after next edge valid_o = 1, dato_o = A, selec_o = 2, gnt_o = 0100 for 1 cycle. One edge later valid_o = 0.
REQ-033 Fairness: req_i = 1111 held, ready_i = 1 -> gnt_o sequence 0001, 0010, 0100, 1000, 0001, spaced 2 cycles apart.
REQ-034 Backpressure: grant to 1 with dato1_i = 5, ready_i = 0 for 5 cycles while dato1_i changes to 9 -> valid_o = 1 and dato_o = 5 throughout, single gnt_o pulse. Completes on the first ready_i = 1.
REQ-035 Pointer: after a transfer from 1, req_i = 1010 -> grant 3 first, then 1. After a transfer from 3, req_i = 0011 -> grant 0.
REQ-036 Reset in ESPERA: rst_n_i pulsed low while valid_o = 1 -> valid_o = 0 at once. After release with req_i = 0000 -> no gnt_o, no valid_o.

Source files
------------

// File: rtl/module_arbitro_mux4.sv
// Four-requester round-robin arbiter feeding a registered 4-to-1 data mux.
// Each transfer is held in ESPERA until the consumer raises ready_i.
module module_arbitro_mux4 #(
  parameter int BITS = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [3:0]      req_i,
  input  logic [BITS-1:0] dato0_i,
  input  logic [BITS-1:0] dato1_i,
  input  logic [BITS-1:0] dato2_i,
  input  logic [BITS-1:0] dato3_i,
  input  logic            ready_i,
  output logic [3:0]      gnt_o,
  output logic [1:0]      selec_o,
  output logic [BITS-1:0] dato_o,
  output logic            valid_o
);

  typedef enum logic {IDLE = 1'b0, ESPERA = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      ultimo_reg, ultimo_next;
  logic [3:0]      gnt_next;
  logic [1:0]      selec_next;
  logic [BITS-1:0] dato_next;
  logic            valid_next;

  logic [BITS-1:0] dato_arr [4];
  logic [3:0]      req_rot;
  logic [1:0]      hit_off;
  logic [1:0]      winner;
  logic            any_req;

  assign dato_arr[0] = dato0_i;
  assign dato_arr[1] = dato1_i;
  assign dato_arr[2] = dato2_i;
  assign dato_arr[3] = dato3_i;

  // Rotate requests so bit 0 is the requester right after the last served one.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFS = 2'(gi + 1);
      assign req_rot[gi] = req_i[ultimo_reg + OFS];
    end
  endgenerate

  assign any_req = |req_i;

  always_comb begin
    hit_off = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (req_rot[j]) hit_off = 2'(j);
    end
  end

  assign winner = ultimo_reg + hit_off + 2'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= IDLE;
      ultimo_reg <= 2'd3;
      gnt_o      <= 4'd0;
      selec_o    <= 2'd0;
      dato_o     <= '0;
      valid_o    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ultimo_reg <= ultimo_next;
      gnt_o      <= gnt_next;
      selec_o    <= selec_next;
      dato_o     <= dato_next;
      valid_o    <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ESPERA;
      ESPERA:  if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_next    = 4'd0;
    selec_next  = selec_o;
    dato_next   = dato_o;
    valid_next  = valid_o;
    ultimo_next = ultimo_reg;
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        if (any_req) begin
          selec_next = winner;
          dato_next  = dato_arr[winner];
          valid_next = 1'b1;
          gnt_next   = 4'b0001 << winner;
        end
      end
      ESPERA: begin
        // Pointer advances only when the transfer actually completes.
        if (ready_i) begin
          valid_next  = 1'b0;
          ultimo_next = selec_o;
        end
      end
      default: valid_next = 1'b0;
    endcase
  end

endmodule
